// File: rtl/fifo_rd_stream_adapter.sv
// Read-end adapter for show-ahead FIFOs: pops via empty/rd_en and presents a
// registered valid/ready stream through a 2-entry head/skid buffer.

module fifo_rd_stream_adapter_chk (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] occupancy_i,
   input  logic       m_valid_i,
   input  logic       m_ready_i,
   input  logic       fifo_empty_i,
   input  logic       fifo_rd_en_i
);

   occ_upper_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      occupancy_i <= 2'd2);
   occ_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (occupancy_i == 2'd0) |-> !(m_valid_i && m_ready_i));
   valid_matches_occ: assert property (@(posedge clk_i) disable iff (!rst_ni)
      m_valid_i == (occupancy_i != 2'd0));
   no_pop_while_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_empty_i |-> !fifo_rd_en_i);

endmodule

module fifo_rd_stream_adapter #(
   parameter int WIDTH = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] fifo_data_i,
   input  logic             fifo_empty_i,
   output logic             fifo_rd_en_o,
   output logic             m_valid_o,
   output logic [WIDTH-1:0] m_data_o,
   input  logic             m_ready_i,
   output logic [1:0]       occupancy_o
);

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   logic [1:0]       occ_q,   occ_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] head_q,  head_d;
   logic [WIDTH-1:0] skid_q,  skid_d;
   logic             push_s;
   logic             pop_s;

   // State register: occupancy, head, skid and the registered valid flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occ_q   <= OCC_EMPTY;
         valid_q <= 1'b0;
         head_q  <= {WIDTH{1'b0}};
         skid_q  <= {WIDTH{1'b0}};
      end else begin
         occ_q   <= occ_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   // Next-state: push comes from the FIFO pop, pop from the downstream handshake.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      skid_d = skid_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push_s) begin
               occ_d  = OCC_ONE;
               head_d = fifo_data_i;
            end else begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_ONE: begin
            if (push_s && !pop_s) begin
               occ_d  = OCC_TWO;
               skid_d = fifo_data_i;
            end else if (push_s && pop_s) begin
               head_d = fifo_data_i;
            end else if (pop_s) begin
               occ_d  = OCC_EMPTY;
            end else begin
               occ_d  = OCC_ONE;
            end
         end
         OCC_TWO: begin
            if (pop_s) begin
               occ_d  = OCC_ONE;
               head_d = skid_q;
            end else begin
               occ_d  = OCC_TWO;
            end
         end
         default: begin
            occ_d  = OCC_EMPTY;
         end
      endcase
      valid_d = (occ_d != OCC_EMPTY);
   end

   // Outputs: rd_en never looks at m_ready_i, only at empty and registered state.
   always_comb begin
      push_s = rst_ni && !fifo_empty_i && (occ_q < OCC_TWO);
      pop_s  = valid_q && m_ready_i;
   end

   assign fifo_rd_en_o = push_s;
   assign m_valid_o    = valid_q;
   assign m_data_o     = head_q;
   assign occupancy_o  = occ_q;

   fifo_rd_stream_adapter_chk u_chk (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .occupancy_i  (occ_q),
      .m_valid_i    (valid_q),
      .m_ready_i    (m_ready_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rd_en_i (push_s)
   );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Randomised bench for fifo_rd_stream_adapter: a queue-based FIFO source and a
// word-count model (words popped minus words accepted) predict every output.

module tb_fifo_rd_stream_adapter;

   localparam int W = 10;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic [W-1:0] fifo_data_i = '0;
   logic         fifo_empty_i = 1'b1;
   logic         fifo_rd_en_o;
   logic         m_valid_o;
   logic [W-1:0] m_data_o;
   logic         m_ready_i = 1'b0;
   logic [1:0]   occupancy_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] src_q[$];   // words still in the attached FIFO
   logic [W-1:0] sb_q[$];    // words popped but not yet accepted downstream
   logic [W-1:0] out_q[$];   // words accepted downstream, in order

   logic         obs_rd, exp_rd, obs_v, exp_v, obs_empty;
   logic [W-1:0] obs_d, exp_d;
   logic [1:0]   obs_occ;
   int           exp_occ;

   fifo_rd_stream_adapter #(.WIDTH(W)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .fifo_data_i  (fifo_data_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .m_valid_o    (m_valid_o),
      .m_data_o     (m_data_o),
      .m_ready_i    (m_ready_i),
      .occupancy_o  (occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   // One clock of stimulus; leaves observed and predicted values for the caller.
   task automatic drive_cycle(input logic rdy, input logic gate);
      logic push, pop;
      m_ready_i    = rdy;
      fifo_empty_i = gate || (src_q.size() == 0);
      fifo_data_i  = (src_q.size() != 0) ? src_q[0] : W'($urandom);
      #1;
      exp_occ   = sb_q.size();
      exp_rd    = !fifo_empty_i && (exp_occ < 2);
      exp_v     = (exp_occ != 0);
      exp_d     = exp_v ? sb_q[0] : '0;
      obs_rd    = fifo_rd_en_o;
      obs_v     = m_valid_o;
      obs_d     = m_data_o;
      obs_occ   = occupancy_o;
      obs_empty = fifo_empty_i;
      push = exp_rd;
      pop  = exp_v && rdy;
      @(posedge clk_i);
      if (push) sb_q.push_back(src_q.pop_front());
      if (pop) out_q.push_back(sb_q.pop_front());
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      fifo_empty_i = 1'b0;
      fifo_data_i = 10'h155;
      m_ready_i = 1'b0;
      sb_q.delete(); src_q.delete(); out_q.delete();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i); #1;
      n_checks++;
      if (fifo_rd_en_o !== 1'b0 || m_valid_o !== 1'b0 || m_data_o !== 10'h000 || occupancy_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: rd_en=%b valid=%b data=%h occ=%0d, want 0 0 000 0",
                  fifo_rd_en_o, m_valid_o, m_data_o, occupancy_o);
      end
      @(negedge clk_i);
      src_q.push_back(10'h155);
      rst_ni = 1'b1;
      drive_cycle(1'b0, 1'b0);
      n_checks++;
      if (obs_rd !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_rd_en: got %b want 1", obs_rd);
      end
      drive_cycle(1'b1, 1'b0);
      n_checks++;
      if (obs_v !== 1'b1 || obs_d !== 10'h155 || obs_occ !== 2'd1) begin
         n_fail++;
         $display("FAIL reset_first_word: valid=%b data=%h occ=%0d want 1 155 1", obs_v, obs_d, obs_occ);
      end
      drive_cycle(1'b1, 1'b0);
      n_checks++;
      if (obs_v !== 1'b0 || obs_occ !== 2'd0) begin
         n_fail++; $display("FAIL reset_drain: valid=%b occ=%0d want 0 0", obs_v, obs_occ);
      end
   endtask

   task automatic test_streaming();
      int rd_cnt = 0;
      out_q.delete();
      for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
      for (int c = 0; c < 10; c++) begin
         drive_cycle(1'b1, 1'b0);
         if (c < 8 && obs_rd) rd_cnt++;
         n_checks++;
         if (obs_rd !== exp_rd || obs_v !== exp_v || obs_occ !== 2'(exp_occ) || (exp_v && obs_d !== exp_d)) begin
            n_fail++;
            $display("FAIL stream_cycle%0d: rd=%b v=%b d=%h occ=%0d want rd=%b v=%b d=%h occ=%0d",
                     c, obs_rd, obs_v, obs_d, obs_occ, exp_rd, exp_v, exp_d, exp_occ);
         end
         if (c >= 1 && c <= 8) begin
            n_checks++;
            if (obs_v !== 1'b1 || obs_d !== W'(c) || obs_occ !== 2'd1) begin
               n_fail++;
               $display("FAIL stream_word%0d: v=%b d=%h occ=%0d want 1 %h 1", c, obs_v, obs_d, obs_occ, W'(c));
            end
         end
      end
      n_checks++;
      if (rd_cnt != 8 || out_q.size() != 8 || obs_v !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_totals: rd_cycles=%0d delivered=%0d final_valid=%b want 8 8 0", rd_cnt, out_q.size(), obs_v);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] want[4] = '{10'h0A0, 10'h0A1, 10'h0A2, 10'h0A3};
      out_q.delete();
      for (int i = 0; i < 4; i++) src_q.push_back(want[i]);
      for (int c = 0; c < 4; c++) drive_cycle(1'b0, 1'b0);
      drive_cycle(1'b1, 1'b0);
      n_checks++;
      if (obs_occ !== 2'd2 || obs_d !== 10'h0A0 || obs_v !== 1'b1 || src_q.size() != 2 || obs_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_stall: occ=%0d d=%h v=%b fifo_left=%0d rd=%b want 2 0a0 1 2 0",
                  obs_occ, obs_d, obs_v, src_q.size(), obs_rd);
      end
      for (int c = 0; c < 6; c++) begin
         drive_cycle(1'b1, 1'b0);
         n_checks++;
         if (obs_rd !== exp_rd || obs_v !== exp_v || obs_occ !== 2'(exp_occ) || (exp_v && obs_d !== exp_d)) begin
            n_fail++;
            $display("FAIL bp_drain%0d: rd=%b v=%b d=%h occ=%0d want rd=%b v=%b d=%h occ=%0d",
                     c, obs_rd, obs_v, obs_d, obs_occ, exp_rd, exp_v, exp_d, exp_occ);
         end
      end
      n_checks++;
      if (out_q.size() != 4) begin
         n_fail++; $display("FAIL bp_count: got %0d words want 4", out_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_q[i] !== want[i]) begin
               n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, out_q[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] sent[$];
      int cyc = 0;
      out_q.delete();
      for (int i = 0; i < 200; i++) begin
         sent.push_back(W'($urandom));
         src_q.push_back(sent[i]);
      end
      while (out_q.size() < 200 && cyc < 3000) begin
         drive_cycle(1'($urandom_range(1)), ($urandom_range(2) == 0));
         cyc++;
         n_checks++;
         if (obs_rd !== exp_rd || obs_v !== exp_v || obs_occ !== 2'(exp_occ) || (exp_v && obs_d !== exp_d)
             || obs_occ > 2'd2 || (obs_rd && obs_empty)) begin
            n_fail++;
            $display("FAIL rand_cycle%0d: rd=%b empty=%b v=%b d=%h occ=%0d want rd=%b v=%b d=%h occ=%0d",
                     cyc, obs_rd, obs_empty, obs_v, obs_d, obs_occ, exp_rd, exp_v, exp_d, exp_occ);
         end
      end
      n_checks++;
      if (out_q.size() != 200) begin
         n_fail++; $display("FAIL rand_timeout: delivered %0d want 200", out_q.size());
      end else begin
         n_checks++;
         if (out_q != sent) begin
            n_fail++; $display("FAIL rand_sequence: delivered stream differs from FIFO order");
         end
      end
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
   endtask

   task automatic test_mid_reset();
      out_q.delete();
      src_q.push_back(10'h3FF);
      src_q.push_back(10'h200);
      src_q.push_back(10'h123);
      for (int c = 0; c < 3; c++) drive_cycle(1'b0, 1'b0);
      n_checks++;
      if (obs_occ !== 2'd2 || obs_d !== 10'h3FF) begin
         n_fail++; $display("FAIL mid_setup: occ=%0d d=%h want 2 3ff", obs_occ, obs_d);
      end
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (m_valid_o !== 1'b0 || occupancy_o !== 2'd0 || fifo_rd_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_async_drop: v=%b occ=%0d rd=%b want 0 0 0", m_valid_o, occupancy_o, fifo_rd_en_o);
      end
      #1 rst_ni = 1'b1;
      sb_q.delete();
      drive_cycle(1'b1, 1'b0);
      drive_cycle(1'b1, 1'b0);
      n_checks++;
      if (obs_v !== 1'b1 || obs_d !== 10'h123) begin
         n_fail++; $display("FAIL mid_next_word: v=%b d=%h want 1 123", obs_v, obs_d);
      end
      drive_cycle(1'b1, 1'b0);
      n_checks++;
      if (out_q.size() != 1 || obs_v !== 1'b0) begin
         n_fail++; $display("FAIL mid_discard: delivered=%0d v=%b want 1 0", out_q.size(), obs_v);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
